// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding pattern_matcher.a: valid/ready word intake,
// MSB- or LSB-first shifting, optional idle gap, and registered a_valid/done framing.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_ready,
    input  logic             abort,
    output logic             a,
    output logic             a_valid,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam logic [4:0] BCNT_LAST = 5'(WIDTH - 1);
    localparam logic [7:0] GCNT_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit         NO_GAP    = (GAP == 0);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [4:0]       r_bcnt;
    logic [7:0]       r_gcnt;
    logic             r_a;
    logic             r_a_valid;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_adv;
    logic [4:0]       w_bcnt_nxt;
    logic [4:0]       w_bcnt_inc;
    logic [7:0]       w_gcnt_nxt;
    logic             w_a_nxt;
    logic             w_a_valid_nxt;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_accept;

    // The register always holds the bit currently on `a` at its head position.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign w_last      = (r_state == ST_SHIFT) && (r_bcnt == BCNT_LAST);
    assign in_ready    = !reset && !abort && ((r_state == ST_IDLE) || (w_last && NO_GAP));
    assign w_accept    = in_valid && in_ready;
    assign w_shift_adv = advance(r_shift);
    assign w_bcnt_inc  = r_bcnt + 5'd1;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bcnt_nxt    = r_bcnt;
        w_gcnt_nxt    = r_gcnt;
        w_a_nxt       = IDLE_BIT;
        w_a_valid_nxt = 1'b0;
        w_done_nxt    = 1'b0;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_bcnt_nxt  = '0;
            w_gcnt_nxt  = '0;
        end else if (w_accept) begin
            w_state_nxt   = ST_SHIFT;
            w_shift_nxt   = data_in;
            w_bcnt_nxt    = '0;
            w_a_nxt       = head_bit(data_in);
            w_a_valid_nxt = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        w_bcnt_nxt  = '0;
                        w_gcnt_nxt  = '0;
                        w_state_nxt = NO_GAP ? ST_IDLE : ST_GAP;
                    end else begin
                        w_shift_nxt   = w_shift_adv;
                        w_bcnt_nxt    = w_bcnt_inc;
                        w_a_nxt       = head_bit(w_shift_adv);
                        w_a_valid_nxt = 1'b1;
                        w_done_nxt    = (w_bcnt_inc == BCNT_LAST);
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == GCNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_gcnt_nxt  = '0;
                    end else begin
                        w_gcnt_nxt = r_gcnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bcnt    <= '0;
            r_gcnt    <= '0;
            r_a       <= IDLE_BIT;
            r_a_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_gcnt    <= w_gcnt_nxt;
            r_a       <= w_a_nxt;
            r_a_valid <= w_a_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // NOTE: the data register is left unreset; it is always loaded before anything reads it.
    always_ff @(posedge CLK) begin
        r_shift <= w_shift_nxt;
    end

    assign a       = r_a;
    assign a_valid = r_a_valid;
    assign done    = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed vector table on three configurations
// plus randomized traffic compared against a schedule-based reference model.
module tb_bit_serializer;

    logic       CLK = 1'b0;
    logic [2:0] reset;
    logic [2:0] in_valid;
    logic [2:0] abort;
    logic [7:0] data_in [3];
    logic [2:0] in_ready;
    logic [2:0] a;
    logic [2:0] a_valid;
    logic [2:0] done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // Instance 0: MSB-first, no gap. 1: LSB-first, no gap. 2: MSB-first, gap of 2.
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) u_msb (
        .CLK(CLK), .reset(reset[0]), .in_valid(in_valid[0]), .data_in(data_in[0]),
        .in_ready(in_ready[0]), .abort(abort[0]), .a(a[0]), .a_valid(a_valid[0]), .done(done[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_BIT(1'b0)) u_lsb (
        .CLK(CLK), .reset(reset[1]), .in_valid(in_valid[1]), .data_in(data_in[1]),
        .in_ready(in_ready[1]), .abort(abort[1]), .a(a[1]), .a_valid(a_valid[1]), .done(done[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2), .IDLE_BIT(1'b0)) u_gap (
        .CLK(CLK), .reset(reset[2]), .in_valid(in_valid[2]), .data_in(data_in[2]),
        .in_ready(in_ready[2]), .abort(abort[2]), .a(a[2]), .a_valid(a_valid[2]), .done(done[2]));

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic vld, input logic [7:0] d,
                         input logic abt, input logic rst);
        in_valid = '0;
        abort    = '0;
        reset    = '0;
        for (int k = 0; k < 3; k++) data_in[k] = 8'h00;
        in_valid[sel] = vld;
        abort[sel]    = abt;
        reset[sel]    = rst;
        data_in[sel]  = d;
    endtask

    // Directed vectors: inputs applied in a cycle and the outputs required in that same cycle.
    typedef struct {
        int         inst;
        logic       vld;
        logic [7:0] data;
        logic       abt;
        logic       rst;
        logic       ea;
        logic       ev;
        logic       ed;
        logic       er;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int inst, input logic vld, input logic [7:0] data,
                                input logic abt, input logic rst, input logic ea, input logic ev,
                                input logic ed, input logic er, input string name);
        vec_t v;
        v.inst = inst; v.vld = vld; v.data = data; v.abt = abt; v.rst = rst;
        v.ea = ea; v.ev = ev; v.ed = ed; v.er = er; v.name = name;
        vecs.push_back(v);
    endfunction

    // Eight bit cycles; seq lists the required `a` values left to right.
    function automatic void add_run(input int inst, input logic [7:0] seq, input logic vld,
                                    input logic [7:0] data, input logic rdy_last, input string name);
        for (int i = 0; i < 8; i++)
            add(inst, vld, data, 1'b0, 1'b0, seq[7-i], 1'b1, i == 7, (i == 7) && rdy_last,
                $sformatf("%s bit%0d", name, i));
    endfunction

    // Reference model: a schedule of future output cycles; a word accept appends its bits
    // and any gap cycles, and each edge moves the head of the schedule onto the outputs.
    typedef struct packed {
        logic a;
        logic v;
        logic d;
        logic g;
    } out_t;

    localparam out_t M_IDLE = '{a: 1'b0, v: 1'b0, d: 1'b0, g: 1'b0};
    localparam out_t M_GAP  = '{a: 1'b0, v: 1'b0, d: 1'b0, g: 1'b1};

    out_t m_cur;
    out_t m_sched[$];

    function automatic logic m_ready(input logic rst, input logic abt);
        return !rst && !abt && (m_sched.size() == 0) && !m_cur.g;
    endfunction

    function automatic void m_edge(input logic vld, input logic [7:0] d, input logic abt,
                                   input logic rst, input bit msb, input int gap);
        out_t e;
        if (rst || abt) begin
            m_sched.delete();
            m_cur = M_IDLE;
        end else begin
            if (vld && m_ready(1'b0, 1'b0)) begin
                for (int i = 0; i < 8; i++) begin
                    e.a = msb ? d[7-i] : d[i];
                    e.v = 1'b1;
                    e.d = (i == 7);
                    e.g = 1'b0;
                    m_sched.push_back(e);
                end
                for (int i = 0; i < gap; i++) m_sched.push_back(M_GAP);
            end
            if (m_sched.size() != 0) m_cur = m_sched.pop_front();
            else m_cur = M_IDLE;
        end
    endfunction

    bit msb_of[3] = '{1'b1, 1'b0, 1'b1};
    int gap_of[3] = '{0, 0, 2};

    initial begin
        // MSB-first single word 8'hB4.
        add(0, 1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "msb accept");
        add_run(0, 8'b10110100, 1'b0, 8'h00, 1'b1, "msb");
        add(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "msb idle");
        // LSB-first single word 8'hB4.
        add(1, 1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "lsb accept");
        add_run(1, 8'b00101101, 1'b0, 8'h00, 1'b1, "lsb");
        add(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "lsb idle");
        // Back-to-back FF then 00; data_in changes mid-word must not disturb the word.
        add(0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b accept");
        add_run(0, 8'hFF, 1'b1, 8'h00, 1'b1, "b2b w0");
        add_run(0, 8'h00, 1'b0, 8'h00, 1'b1, "b2b w1");
        add(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b idle");
        // Gap of 2 with in_valid held high.
        add(2, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gap accept0");
        add_run(2, 8'hA5, 1'b1, 8'h5A, 1'b0, "gap w0");
        add(2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap c9");
        add(2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap c10");
        add(2, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gap accept1");
        add_run(2, 8'h5A, 1'b0, 8'h00, 1'b0, "gap w1");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap c20");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap c21");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gap idle");
        // Abort then reset at cycle 4 of 8'hFF; a competing word at cycle 4 must be refused.
        for (int r = 0; r < 2; r++) begin
            string tag = (r == 0) ? "abort" : "reset";
            add(0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, " accept"});
            for (int c = 1; c < 4; c++)
                add(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $sformatf("%s c%0d", tag, c));
            add(0, 1'b1, 8'h00, r == 0, r == 1, 1'b1, 1'b1, 1'b0, 1'b0, {tag, " c4"});
            add(0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, " c5"});
            add_run(0, 8'h81, 1'b0, 8'h00, 1'b1, {tag, " next"});
            add(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, " idle"});
        end
        // Abort during the gap: no remaining gap, next word accepted right after.
        add(2, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gabort accept");
        add_run(2, 8'hFF, 1'b0, 8'h00, 1'b0, "gabort w0");
        add(2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gabort c9");
        add(2, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gabort c10");
        add_run(2, 8'h3C, 1'b0, 8'h00, 1'b0, "gabort w1");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gabort gap0");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gabort gap1");
        add(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "gabort idle");

        // Reset all instances, then check reset state and the first ready cycle.
        in_valid = '0;
        abort    = '0;
        reset    = 3'b111;
        for (int k = 0; k < 3; k++) data_in[k] = 8'h00;
        @(posedge CLK); #1;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d a", k), a[k], 1'b0);
            check($sformatf("rst%0d a_valid", k), a_valid[k], 1'b0);
            check($sformatf("rst%0d done", k), done[k], 1'b0);
            check($sformatf("rst%0d in_ready", k), in_ready[k], 1'b0);
        end
        @(posedge CLK); #1;
        reset = '0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++)
            check($sformatf("post-rst%0d in_ready", k), in_ready[k], 1'b1);
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].inst, vecs[i].vld, vecs[i].data, vecs[i].abt, vecs[i].rst);
            @(negedge CLK);
            check({vecs[i].name, " a"}, a[vecs[i].inst], vecs[i].ea);
            check({vecs[i].name, " a_valid"}, a_valid[vecs[i].inst], vecs[i].ev);
            check({vecs[i].name, " done"}, done[vecs[i].inst], vecs[i].ed);
            check({vecs[i].name, " in_ready"}, in_ready[vecs[i].inst], vecs[i].er);
            @(posedge CLK); #1;
        end

        // Randomized traffic on each configuration against the schedule model.
        for (int sel = 0; sel < 3; sel++) begin
            m_sched.delete();
            m_cur = M_IDLE;
            for (int c = 0; c < 800; c++) begin
                logic       vld;
                logic [7:0] d;
                logic       abt;
                logic       rst;
                vld = ($urandom_range(0, 9) < 7);
                d   = 8'($urandom);
                abt = ($urandom_range(0, 99) < 3);
                rst = ($urandom_range(0, 99) < 2);
                drive(sel, vld, d, abt, rst);
                @(negedge CLK);
                check($sformatf("rand%0d c%0d a", sel, c), a[sel], m_cur.a);
                check($sformatf("rand%0d c%0d a_valid", sel, c), a_valid[sel], m_cur.v);
                check($sformatf("rand%0d c%0d done", sel, c), done[sel], m_cur.d);
                check($sformatf("rand%0d c%0d in_ready", sel, c), in_ready[sel], m_ready(rst, abt));
                m_edge(vld, d, abt, rst, msb_of[sel], gap_of[sel]);
                @(posedge CLK); #1;
            end
            drive(sel, 1'b0, 8'h00, 1'b1, 1'b0);
            @(posedge CLK); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

- Upstream stage of `pattern_matcher`: converts parallel words into the serial bit stream on its `a` input, one bit per `CLK`.
- Accepts words through a valid/ready handshake, shifts each word out MSB- or LSB-first, and inserts an optional idle gap between words.
- Flags the active bit window and the final bit of each word, so benches and downstream logic can line the matcher output `b` up against word boundaries.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` is sent first; 0 = bit 0 is sent first.
- `GAP`, 0: idle cycles inserted after each word; legal range 0..255.
- `IDLE_BIT`, 0: value driven on `a` whenever no word bit is being sent.
- `CLK`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  `data_in` holds a word to send.
- `data_in`  input  WIDTH  parallel word; sampled only on the accept edge.
- `in_ready`  output  1  serializer can take a word this cycle.
- `abort`  input  1  synchronous cancel of the word in flight.
- `a`  output  1  registered serial bit; connects to `pattern_matcher.a`.
- `a_valid`  output  1  registered; high while `a` carries a word bit.
- `done`  output  1  registered; high during the cycle `a` carries the last bit of a word.

## Operation
- State machine with three states: IDLE, SHIFT, GAP.
  - A 5-bit bit counter `bcnt` runs 0..WIDTH-1.
  - An 8-bit gap counter `gcnt` runs 0..GAP-1.
- Accept condition: `in_valid & in_ready` at a rising edge.
- IDLE
  - `in_ready`=1, `a`=IDLE_BIT, `a_valid`=0, `done`=0.
  - On accept: load the shift register from `data_in`, set `bcnt`=0, go to SHIFT.
  - The first bit appears on `a` in the cycle after the accept edge.
- SHIFT
  - `a` = current head bit: bit `WIDTH-1-bcnt` if MSB_FIRST, bit `bcnt` otherwise.
  - `a_valid`=1; `bcnt` increments every cycle.
- SHIFT, last bit (`bcnt`=WIDTH-1)
  - `done`=1.
  - If GAP=0, `in_ready`=1 in this cycle. An accept here reloads the shift register and stays in SHIFT, so words run back-to-back with no idle cycle.
  - If GAP=0 and there is no accept, go to IDLE.
  - If GAP>0, `in_ready`=0 and the next state is GAP with `gcnt`=0.
- GAP
  - `a`=IDLE_BIT, `a_valid`=0, `in_ready`=0.
  - Stay exactly GAP cycles, then go to IDLE.
- `in_ready` is combinational from state and counters: `(IDLE) | (SHIFT & bcnt==WIDTH-1 & GAP==0)`. It is forced to 0 while `reset` or `abort` is high.
- `abort` in any state: next state IDLE, `a`=IDLE_BIT, `a_valid`=0, `done`=0. The partial word is discarded and no gap is inserted.
- `abort` wins over a simultaneous `in_valid`; the word is not accepted.
- `data_in` changes while not accepting have no effect. The shift register is the only copy of the word.

## Timing
- Reset values: state IDLE, `a`=IDLE_BIT, `a_valid`=0, `done`=0, `bcnt`=0, `gcnt`=0; `in_ready`=0 while `reset`=1.
- The first `in_ready`=1 is in the cycle after `reset` deasserts.
- Latency: accept edge N → first bit on `a` during cycle N+1 → last bit (`done`=1) during cycle N+WIDTH.
- Throughput
  - GAP=0 with continuous `in_valid`: one bit every cycle, no bubbles.
  - GAP=G>0: one word every WIDTH+G+1 cycles (the IDLE accept cycle counts as one).
- Reset asserted mid-word: takes effect at the next edge, same as `abort`, and returns all reset values above.
- `a`, `a_valid` and `done` change only on rising edges; there are no combinational paths from inputs to these outputs.

## Test plan
- **MSB-first single word.** WIDTH=8, MSB_FIRST=1, GAP=0; accept 8'hB4 at cycle 0.
  - Required: `a` = 1,0,1,1,0,1,0,0 in cycles 1..8.
  - `a_valid`=1 in cycles 1..8 only; `done`=1 in cycle 8 only; back in IDLE with `a`=0 from cycle 9.
- **LSB-first single word.** MSB_FIRST=0, 8'hB4.
  - Required: `a` = 0,0,1,0,1,1,0,1 in cycles 1..8.
- **Back-to-back.** GAP=0, `in_valid` held high with 8'hFF then 8'h00.
  - Required: `in_ready`=1 at cycle 8; `a` = eight 1s then eight 0s with no idle cycle; `a_valid` continuous for 16 cycles.
- **Gap insertion.** GAP=2, IDLE_BIT=0, two words 8'hA5 and 8'h5A with `in_valid` always high.
  - Required: cycles 9–10 have `a_valid`=0 and `in_ready`=0; second accept at cycle 11; its first bit in cycle 12.
- **Abort and reset mid-word.**
  - `abort` at cycle 4 of 8'hFF: `a`=0 and `a_valid`=0 from cycle 5; no `done` pulse; the next word is accepted in cycle 5.
  - Repeat with `reset` in place of `abort`: same response, except `in_ready`=0 while `reset`=1.
- **End-to-end with the matcher.** Stream into `pattern_matcher` a word containing its target pattern and a word without it.
  - Required: `b` asserts only in cycles following the pattern bits.
  - `a_valid` framing confirms the alignment against word boundaries.
